// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared coin codes, coin FSM states and default timing constants
package vend_pkg;

  localparam logic [1:0] COIN_Q = 2'd1;
  localparam logic [1:0] COIN_D = 2'd2;
  localparam logic [1:0] COIN_N = 2'd3;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_FIFO_DEPTH      = 4;
  localparam int DEF_PULSE_GAP       = 1;

  typedef enum logic [1:0] {
    COIN_IDLE  = 2'd0,
    COIN_PULSE = 2'd1,
    COIN_GAP   = 2'd2
  } coin_state_t;

  // Returns {nickel, dime, quarter}; unknown codes map to no output.
  function automatic logic [2:0] coin_onehot(input logic [1:0] code);
    case (code)
      COIN_Q:  coin_onehot = 3'b001;
      COIN_D:  coin_onehot = 3'b010;
      COIN_N:  coin_onehot = 3'b100;
      default: coin_onehot = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/vend_input_conditioner_if.sv
// rtl/vend_input_conditioner_if.sv - raw sensor inputs and conditioned pulse outputs
interface vend_input_conditioner_if #(
  parameter int FIFO_DEPTH = 4
);
  logic raw_quarter;
  logic raw_dime;
  logic raw_nickle;
  logic raw_bev1;
  logic raw_bev2;
  logic raw_bev3;
  logic raw_return;
  logic inquarter;
  logic indime;
  logic innickle;
  logic inbev1;
  logic inbev2;
  logic inbev3;
  logic RETURN;
  logic coin_overflow;
  logic [$clog2(FIFO_DEPTH):0] coin_pending;

  modport master (
    output raw_quarter, raw_dime, raw_nickle, raw_bev1, raw_bev2, raw_bev3, raw_return,
    input  inquarter, indime, innickle, inbev1, inbev2, inbev3, RETURN,
    input  coin_overflow, coin_pending
  );

  modport slave (
    input  raw_quarter, raw_dime, raw_nickle, raw_bev1, raw_bev2, raw_bev3, raw_return,
    output inquarter, indime, innickle, inbev1, inbev2, inbev3, RETURN,
    output coin_overflow, coin_pending
  );
endinterface

// File: rtl/vend_debounce.sv
// rtl/vend_debounce.sv - two-flop synchroniser and counter debouncer with rising-event output
module vend_debounce
  import vend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic CLK,
  input  logic RESET,
  input  logic raw,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Level resets high so an input already asserted at reset must re-arm first.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b1;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
        rise  <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/vend_input_conditioner.sv
// rtl/vend_input_conditioner.sv - debounced coin/button front end with queued one-hot coin pulses
module vend_input_conditioner
  import vend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
  parameter int PULSE_GAP       = DEF_PULSE_GAP
) (
  input logic                  CLK,
  input logic                  RESET,
  vend_input_conditioner_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int GW = $clog2(PULSE_GAP + 1);

  logic [6:0] raw;
  logic [6:0] rise;

  assign raw = {bus.raw_return, bus.raw_bev3, bus.raw_bev2, bus.raw_bev1,
                bus.raw_nickle, bus.raw_dime, bus.raw_quarter};

  for (genvar i = 0; i < 7; i++) begin : g_db
    vend_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .CLK   (CLK),
      .RESET (RESET),
      .raw   (raw[i]),
      .rise  (rise[i])
    );
  end

  logic [1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [PW-1:0] count;
  logic          overflow;
  logic [1:0]    codes [3];
  logic [1:0]    n_ev;
  logic [1:0]    n_acc;
  logic [PW-1:0] space;
  logic          drop;
  logic          pop;
  logic [1:0]    head;

  assign head = mem[rd_ptr];

  // Pack this cycle's coin events in Q, D, N order; only the first n_ev slots matter.
  always_comb begin
    codes[0] = rise[0] ? COIN_Q : (rise[1] ? COIN_D : COIN_N);
    codes[1] = (rise[0] && rise[1]) ? COIN_D : COIN_N;
    codes[2] = COIN_N;
    n_ev     = {1'b0, rise[0]} + {1'b0, rise[1]} + {1'b0, rise[2]};
    space    = PW'(FIFO_DEPTH) - count + PW'(pop);
    drop     = PW'(n_ev) > space;
    n_acc    = drop ? space[1:0] : n_ev;
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      if (i < int'(n_acc)) mem[wr_ptr + AW'(i)] <= codes[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(n_acc);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + PW'(n_acc) - PW'(pop);
      if (drop) overflow <= 1'b1;
    end
  end

  coin_state_t   state;
  coin_state_t   state_n;
  logic [GW-1:0] gap_cnt;
  logic [GW-1:0] gap_n;
  logic [2:0]    coin_out;
  logic [2:0]    coin_n;

  // The last gap cycle can launch the next pulse directly, so the gap is exactly PULSE_GAP idle cycles.
  always_comb begin
    state_n = state;
    gap_n   = gap_cnt;
    pop     = 1'b0;
    coin_n  = 3'b000;
    case (state)
      COIN_IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          coin_n  = coin_onehot(head);
          state_n = COIN_PULSE;
        end
      end
      COIN_PULSE: begin
        gap_n   = '0;
        state_n = COIN_GAP;
      end
      COIN_GAP: begin
        if (gap_cnt == GW'(PULSE_GAP - 1)) begin
          if (count != '0) begin
            pop     = 1'b1;
            coin_n  = coin_onehot(head);
            state_n = COIN_PULSE;
          end else begin
            state_n = COIN_IDLE;
          end
        end else begin
          gap_n = gap_cnt + GW'(1);
        end
      end
      default: state_n = COIN_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= COIN_IDLE;
      gap_cnt  <= '0;
      coin_out <= 3'b000;
    end else begin
      state    <= state_n;
      gap_cnt  <= gap_n;
      coin_out <= coin_n;
    end
  end

  logic [2:0] bev_stage;
  logic [2:0] bev_out;
  logic       ret_stage;
  logic       ret_out;

  // Extra stage keeps button latency equal to the FIFO write plus pop path.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bev_stage <= 3'b000;
      bev_out   <= 3'b000;
      ret_stage <= 1'b0;
      ret_out   <= 1'b0;
    end else begin
      bev_stage <= $onehot(rise[5:3]) ? rise[5:3] : 3'b000;
      bev_out   <= bev_stage;
      ret_stage <= rise[6];
      ret_out   <= ret_stage;
    end
  end

  assign bus.inquarter     = coin_out[0];
  assign bus.indime        = coin_out[1];
  assign bus.innickle      = coin_out[2];
  assign bus.inbev1        = bev_out[0];
  assign bus.inbev2        = bev_out[1];
  assign bus.inbev3        = bev_out[2];
  assign bus.RETURN        = ret_out;
  assign bus.coin_overflow = overflow;
  assign bus.coin_pending  = count;

endmodule
